// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: shared types and width helpers for the mult_acc accumulation stage.
package mult_acc_pkg;

    // Two-state group FSM: collecting products, or holding a finished result.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Accumulator width: full product plus guard bits.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned guard);
        return 2 * width + guard;
    endfunction

    // Per-group product counter width.
    function automatic int unsigned cnt_width(input int unsigned count);
        return $clog2(count);
    endfunction

endpackage

// File: rtl/mult_acc_sat_add.sv
// mult_acc_sat_add: ACC_W unsigned adder with carry-out.
// With MULT_ACC_SAT_EN defined, a carry saturates the result to all ones;
// otherwise the result wraps modulo 2^ACC_W.
module mult_acc_sat_add #(
    parameter int unsigned ACC_W = 72
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum_c,
    output logic             o_carry_c
);

    logic [ACC_W:0] w_full;

    // One bit wider than the operands so the carry-out is visible.
    always_comb begin
        w_full    = {1'b0, i_a} + {1'b0, i_b};
        o_carry_c = w_full[ACC_W];
`ifdef MULT_ACC_SAT_EN
        o_sum_c   = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
        o_sum_c   = w_full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mult_acc.sv
// mult_acc: sums each group of COUNT {hi, lo} products into one ACC_W result,
// with valid/ready on both sides and zero-bubble chaining between groups.
// Optional feature macro: MULT_ACC_SAT_EN (saturating accumulation).
module mult_acc
    import mult_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned COUNT = 8,
    parameter int unsigned GUARD = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WIDTH-1:0]                     hi,
    input  logic [WIDTH-1:0]                     lo,
    input  logic                                 valid_in,
    output logic                                 ready_out,
    output logic [acc_width(WIDTH, GUARD)-1:0]   sum,
    output logic                                 ovf,
    output logic                                 valid_out,
    input  logic                                 ready_in
);

    localparam int unsigned ACC_W = acc_width(WIDTH, GUARD);
    localparam int unsigned CNT_W = cnt_width(COUNT);

    if (COUNT < 2) begin : g_bad_count
        $error("mult_acc: COUNT must be at least 2");
    end

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_grp_ovf;
    logic [ACC_W-1:0]   r_sum;
    logic               r_ovf;
    logic               r_valid_out;

    logic [ACC_W-1:0]   w_p;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_carry;
    logic               w_grp_ovf;
    logic               w_accept;
    logic               w_emit;
    logic               w_last;

    // Running accumulator plus incoming product.
    mult_acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a       (r_acc),
        .i_b       (w_p),
        .o_sum_c   (w_add_sum),
        .o_carry_c (w_add_carry)
    );

    // Handshake decode; ready_out depends only on state, ready_in and reset.
    always_comb begin
        w_p       = ACC_W'({hi, lo});
        ready_out = !rst && ((r_state == ACCUM) || ready_in);
        w_accept  = valid_in && ready_out;
        w_emit    = r_valid_out && ready_in;
        w_last    = (r_cnt == CNT_W'(COUNT - 1));
        w_grp_ovf = r_grp_ovf || w_add_carry;
    end

    // Group FSM: accumulate COUNT products, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_grp_ovf   <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_sum       <= w_add_sum;
                            r_ovf       <= w_grp_ovf;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_grp_ovf   <= 1'b0;
                            r_valid_out <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_acc       <= w_add_sum;
                            r_cnt       <= r_cnt + CNT_W'(1);
                            r_grp_ovf   <= w_grp_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (w_emit) begin
                        r_valid_out <= 1'b0;
                        r_state     <= ACCUM;
                        r_grp_ovf   <= 1'b0;
                        // A product accepted on the emit edge opens the next group.
                        if (w_accept) begin
                            r_acc <= w_p;
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign ovf       = r_ovf;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_mult_acc.sv
// tb_mult_acc: directed self-checking bench for mult_acc (COUNT=4, WIDTH=32).
// A second instance with GUARD=1 covers accumulator overflow.
module tb_mult_acc;

    logic        clk;
    logic        rst;

    // Main instance, GUARD = 8 (ACC_W = 72).
    logic [31:0] hi, lo;
    logic        valid_in, ready_in;
    logic        ready_out, ovf, valid_out;
    logic [71:0] sum;

    // Overflow instance, GUARD = 1 (ACC_W = 65).
    logic [31:0] hi2, lo2;
    logic        valid_in2, ready_in2;
    logic        ready_out2, ovf2, valid_out2;
    logic [64:0] sum2;

    int unsigned n_pass;
    int unsigned n_total;

    mult_acc #(.WIDTH(32), .COUNT(4), .GUARD(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .hi        (hi),
        .lo        (lo),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .sum       (sum),
        .ovf       (ovf),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    mult_acc #(.WIDTH(32), .COUNT(4), .GUARD(1)) u_ovf (
        .clk       (clk),
        .rst       (rst),
        .hi        (hi2),
        .lo        (lo2),
        .valid_in  (valid_in2),
        .ready_out (ready_out2),
        .sum       (sum2),
        .ovf       (ovf2),
        .valid_out (valid_out2),
        .ready_in  (ready_in2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] p);
        {hi, lo} = p;
        valid_in = 1'b1;
        tick();
    endtask

    task automatic push2(input logic [63:0] p);
        {hi2, lo2} = p;
        valid_in2 = 1'b1;
        tick();
    endtask

    logic [64:0] exp_ovf_sum;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        hi        = '0;
        lo        = '0;
        valid_in  = 1'b0;
        ready_in  = 1'b1;
        hi2       = '0;
        lo2       = '0;
        valid_in2 = 1'b0;
        ready_in2 = 1'b1;
`ifdef MULT_ACC_SAT_EN
        exp_ovf_sum = 65'h1_FFFF_FFFF_FFFF_FFFF;
`else
        exp_ovf_sum = 65'h1_FFFF_FFFF_FFFF_FFFC;
`endif

        // Reset state
        tick();
        tick();
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_ready_out", 128'(ready_out), 128'(0));
        check("rst_sum", 128'(sum), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready_out", 128'(ready_out), 128'(1));

        // Basic accumulation 1+2+3+4
        push(64'd1);
        push(64'd2);
        push(64'd3);
        check("basic_not_yet_valid", 128'(valid_out), 128'(0));
        push(64'd4);
        valid_in = 1'b0;
        check("basic_valid", 128'(valid_out), 128'(1));
        check("basic_sum", 128'(sum), 128'(10));
        check("basic_ovf", 128'(ovf), 128'(0));
        tick();
        check("basic_one_cycle", 128'(valid_out), 128'(0));

        // Backpressure: group of 5s held while ready_in is low
        for (int i = 0; i < 4; i++) push(64'd5);
        check("bp_valid", 128'(valid_out), 128'(1));
        check("bp_sum", 128'(sum), 128'(20));
        ready_in = 1'b0;
        {hi, lo} = 64'd6;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready_out_low", 128'(ready_out), 128'(0));
            tick();
            check("bp_sum_held", 128'(sum), 128'(20));
            check("bp_valid_held", 128'(valid_out), 128'(1));
        end
        ready_in = 1'b1;
        #1;
        check("bp_release_ready", 128'(ready_out), 128'(1));
        tick();
        check("bp_emit_once", 128'(valid_out), 128'(0));
        push(64'd6);
        push(64'd6);
        push(64'd6);
        valid_in = 1'b0;
        check("bp_resume_valid", 128'(valid_out), 128'(1));
        check("bp_resume_sum", 128'(sum), 128'(24));
        tick();

        // Chaining: continuous 1..8, no bubble
        for (int i = 1; i <= 8; i++) begin
            {hi, lo} = 64'(i);
            valid_in = 1'b1;
            #1;
            check("chain_ready_out", 128'(ready_out), 128'(1));
            tick();
            if (i == 4) begin
                check("chain_first_valid", 128'(valid_out), 128'(1));
                check("chain_first_sum", 128'(sum), 128'(10));
            end
            if (i == 5) check("chain_gap_valid", 128'(valid_out), 128'(0));
        end
        valid_in = 1'b0;
        check("chain_second_valid", 128'(valid_out), 128'(1));
        check("chain_second_sum", 128'(sum), 128'(26));
        tick();

        // Reset mid-group discards the partial sum
        push(64'd7);
        push(64'd9);
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_ready_out", 128'(ready_out), 128'(0));
        tick();
        check("midrst_valid_out", 128'(valid_out), 128'(0));
        check("midrst_sum", 128'(sum), 128'(0));
        check("midrst_ovf", 128'(ovf), 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(64'd1);
        valid_in = 1'b0;
        check("midrst_valid", 128'(valid_out), 128'(1));
        check("midrst_sum_after", 128'(sum), 128'(4));
        tick();

        // Idle input inside a partial group leaves acc/cnt untouched
        push(64'd2);
        valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid_out", 128'(valid_out), 128'(0));
        end
        push(64'd3);
        push(64'd4);
        check("idle_not_yet_valid", 128'(valid_out), 128'(0));
        push(64'd5);
        valid_in = 1'b0;
        check("idle_valid", 128'(valid_out), 128'(1));
        check("idle_sum", 128'(sum), 128'(14));
        tick();

        // Overflow with GUARD = 1
        for (int i = 0; i < 4; i++) push2(64'hFFFF_FFFF_FFFF_FFFF);
        valid_in2 = 1'b0;
        check("ovf_valid", 128'(valid_out2), 128'(1));
        check("ovf_sum", 128'(sum2), 128'(exp_ovf_sum));
        check("ovf_flag", 128'(ovf2), 128'(1));
        tick();
        for (int i = 0; i < 4; i++) push2(64'd1);
        valid_in2 = 1'b0;
        check("ovf_clear_valid", 128'(valid_out2), 128'(1));
        check("ovf_clear_sum", 128'(sum2), 128'(4));
        check("ovf_clear_flag", 128'(ovf2), 128'(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_acc.md
# mult_acc

Downstream accumulation stage for the `mult_ex` multiplier. It consumes the `{hi, lo}` product stream through a valid/ready handshake and sums each group of `COUNT` consecutive products into one wide result. It presents that result to the next consumer, also through valid/ready. Its upstream port pair mirrors the multiplier's output pair, so the two connect directly.

## Interface
- `WIDTH`, default 32: width of each of `hi` and `lo`. The product is `2*WIDTH` bits.
- `COUNT`, default 8: products per group. Must be ≥ 2; an elaboration-time check fails otherwise.
- `GUARD`, default 8: extra accumulator bits. `ACC_W = 2*WIDTH + GUARD`.
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `hi`, input, `WIDTH`: upper half of the product.
- `lo`, input, `WIDTH`: lower half of the product.
- `valid_in`, input, 1: upstream product is valid.
- `ready_out`, output, 1: this block accepts a product this cycle.
- `sum`, output, `ACC_W`: accumulated group result.
- `ovf`, output, 1: the group overflowed `ACC_W`. Qualified by `valid_out`.
- `valid_out`, output, 1: `sum` and `ovf` are valid.
- `ready_in`, input, 1: the downstream consumer accepts `sum`.

## Operation
- Accept: the product `p = {hi, lo}`, zero-extended to `ACC_W`, is accepted when `valid_in && ready_out`. Emit: a result is taken when `valid_out && ready_in`.
- FSM states:
  - `ACCUM`: `ready_out = 1`, `valid_out = 0`.
  - `HOLD`: `ready_out = ready_in`, `valid_out = 1`.
- In `ACCUM`, on accept:
  - `acc <= acc + p` and `cnt <= cnt + 1`.
  - When `cnt == COUNT-1`, the block instead loads `sum <= acc + p` and `ovf` for the group, clears `acc` and `cnt`, and moves to `HOLD`.
- In `HOLD`:
  - `sum` and `ovf` are held stable until emit.
  - Emit without accept: go to `ACCUM` with `acc = 0`, `cnt = 0`.
  - Emit with simultaneous accept (zero-bubble chaining): go to `ACCUM` with `acc <= p` and `cnt <= 1`.
  - `ready_in = 0`: no accept and no state change. `valid_in` is ignored.
- Arithmetic:
  - Unsigned throughout.
  - The adder is `ACC_W + 1` bits; its carry-out marks overflow for that addition.
  - The group `ovf` is sticky across the group and clears when a new group starts.
- Reset (`rst` high at an edge, from any state):
  - State returns to `ACCUM`; `acc`, `cnt`, `sum`, `ovf` and `valid_out` all go to 0.
  - A partial group is discarded.
  - `ready_out` is forced to 0 while `rst` is high.

## Timing
- `valid_out` rises on the edge that accepts the `COUNT`-th product: latency is 1 cycle from the last accept to visible `sum`.
- `sum`, `ovf` and `valid_out` are registered. `ready_out` is combinational from the state and `ready_in` only.
- There is no combinational path from `valid_in` to any output.
- Sustained throughput is one product per cycle when `ready_in` is held at 1. No bubble is inserted at group boundaries.

## Configuration
- `MULT_ACC_SAT_EN` defined:
  - When the carry-out of any addition is 1, the accumulator saturates to all ones (`{ACC_W{1'b1}}`) and stays saturated for the rest of the group.
  - `ovf` is set for the group.
- `MULT_ACC_SAT_EN` not defined:
  - The accumulator wraps modulo 2^`ACC_W`.
  - `ovf` is still reported as the sticky carry-out.

## Structure
- `mult_acc_pkg` holds:
  - the `state_t` enum (`ACCUM`, `HOLD`);
  - a function computing `ACC_W` from `WIDTH` and `GUARD`;
  - the `COUNT` counter-width constant derivation (`$clog2(COUNT)`).
- One sub-module: `mult_acc_sat_add`. It is the `ACC_W` adder that outputs the next accumulator value and the carry flag, with the `MULT_ACC_SAT_EN`-controlled saturation inside it.

## Test plan
All scenarios use `WIDTH=32` and `COUNT=4` unless stated otherwise.

- Basic accumulation: products 1, 2, 3, 4 on consecutive cycles, `ready_in = 1` → `valid_out` high for exactly 1 cycle, one cycle after the 4th accept, with `sum = 10` and `ovf = 0`.
- Backpressure: after a group of four 5s, hold `ready_in = 0` for 5 cycles with `valid_in = 1` →
  - `sum = 20` is held stable;
  - `ready_out = 0` and no product is accepted;
  - on release, exactly one emit occurs and accepting resumes the same cycle.
- Chaining: a continuous stream of products 1..8 with `ready_in = 1` → two results, 10 then 26, with `ready_out` never low.
- Overflow (`GUARD = 1`): four products of `64'hFFFF_FFFF_FFFF_FFFF` →
  - with `MULT_ACC_SAT_EN`: `sum = 65'h1_FFFF_FFFF_FFFF_FFFF`, `ovf = 1`;
  - without it: `sum = 65'h1_FFFF_FFFF_FFFF_FFFC`, `ovf = 1`.
- Reset mid-group: accept 7 and 9, pulse `rst` for 1 cycle, then accept 1, 1, 1, 1 → `sum = 4`. During reset `valid_out`, `ready_out`, `sum` and `ovf` are all 0.
- Idle input: `valid_in = 0` for 10 cycles in `ACCUM` → `cnt` and `acc` are unchanged and `valid_out` stays 0.
